// File: rtl/cga_mac_xagen.sv
// cga_mac_xagen - extended-address generator for the CGA MAC path.
//
// Builds a logical effective address from a selected CPU register plus an
// optional CD displacement. The address is translated through a bank of
// per-page-table segment base registers. One or two physical addresses are
// delivered over a valid/ready handshake.
//
// Ports
//   MCLK, RESETN        clock (rising edge) / asynchronous active-low reset
//   REQ, DOUBLE         start an access (sampled in IDLE); two-beat access
//   SRC_SEL, CDS        operand select (PR/BR/XR/RB/LCA/zero); add CD
//   PR, BR, XR, RB, CD  operand sources and displacement
//   PONI, PTSEL         translation enable and page-table select (latched with REQ)
//   SEG_WE/IDX/BASE/VLD segment register write port
//   LA_READY            consumer accepts LA
//   ACK, BUSY           request accepted pulse; access in progress
//   LA, LA_VALID, LA_LAST  physical address beat and its handshake flags
//   FAULT               pulse when translating through an invalid entry
//   LCA, NLCA           latched logical address and LCA+1
//
// States
//   state   | meaning
//   S_IDLE  | waiting for REQ
//   S_XLATE | translating LCA into LA (one cycle per beat)
//   S_OUT   | LA_VALID high, waiting for LA_READY
//   S_FAULT | one-cycle FAULT pulse, then back to IDLE
module cga_mac_xagen #(
  parameter int AW        = 16,
  parameter int PAW       = 24,
  parameter int PAGE_BITS = 10,
  parameter int PT_N      = 4,
  localparam int PSW      = (PT_N > 1) ? $clog2(PT_N) : 1,
  localparam int SBW      = PAW - PAGE_BITS
) (
  input  logic           MCLK,
  input  logic           RESETN,
  input  logic           REQ,
  input  logic           DOUBLE,
  input  logic [2:0]     SRC_SEL,
  input  logic           CDS,
  input  logic [AW-1:0]  PR,
  input  logic [AW-1:0]  BR,
  input  logic [AW-1:0]  XR,
  input  logic [AW-1:0]  RB,
  input  logic [AW-1:0]  CD,
  input  logic           PONI,
  input  logic [PSW-1:0] PTSEL,
  input  logic           SEG_WE,
  input  logic [PSW-1:0] SEG_IDX,
  input  logic [SBW-1:0] SEG_BASE,
  input  logic           SEG_VLD,
  input  logic           LA_READY,
  output logic           ACK,
  output logic           BUSY,
  output logic [PAW-1:0] LA,
  output logic           LA_VALID,
  output logic           LA_LAST,
  output logic           FAULT,
  output logic [AW-1:0]  LCA,
  output logic [AW-1:0]  NLCA
);

  typedef enum logic [1:0] {S_IDLE, S_XLATE, S_OUT, S_FAULT} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  lca_q;
  logic [PAW-1:0] la_q;
  logic           dbl_q, poni_q, beat_q;
  logic [PSW-1:0] ptsel_q;
  logic [SBW-1:0] seg_base_q [PT_N];
  logic           seg_vld_q  [PT_N];

  logic [AW-1:0]  operand, ea, nlca;
  logic [SBW-1:0] page_ext, seg_sum;
  logic [PAW-1:0] xlat_la, flat_la;
  logic           accept, xfer, seg_fault;

  always_comb begin
    operand = '0;
    case (SRC_SEL)
      3'd0:    operand = PR;
      3'd1:    operand = BR;
      3'd2:    operand = XR;
      3'd3:    operand = RB;
      3'd4:    operand = lca_q;
      default: operand = '0;
    endcase
  end

  assign ea   = operand + (CDS ? CD : '0);
  assign nlca = lca_q + 1'b1;

  // Page number is zero-extended (or truncated) to the segment base width;
  // the sum wraps modulo 2^SBW.
  assign page_ext  = SBW'(lca_q[AW-1:PAGE_BITS]);
  assign seg_sum   = seg_base_q[ptsel_q] + page_ext;
  assign xlat_la   = {seg_sum, lca_q[PAGE_BITS-1:0]};
  assign flat_la   = PAW'(lca_q);
  assign seg_fault = poni_q && !seg_vld_q[ptsel_q];

  assign accept = (state_q == S_IDLE) && REQ;
  assign xfer   = (state_q == S_OUT) && LA_READY;

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (REQ) state_d = S_XLATE;
      S_XLATE: state_d = seg_fault ? S_FAULT : S_OUT;
      S_OUT:   if (LA_READY) state_d = (dbl_q && !beat_q) ? S_XLATE : S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      lca_q   <= '0;
      la_q    <= '0;
      dbl_q   <= 1'b0;
      poni_q  <= 1'b0;
      beat_q  <= 1'b0;
      ptsel_q <= '0;
      for (int i = 0; i < PT_N; i++) begin
        seg_base_q[i] <= '0;
        seg_vld_q[i]  <= 1'b0;
      end
    end else begin
      // A write lands at this edge; an XLATE in the same cycle has already
      // used the old entry.
      if (SEG_WE) begin
        seg_base_q[SEG_IDX] <= SEG_BASE;
        seg_vld_q[SEG_IDX]  <= SEG_VLD;
      end
      if (accept) begin
        lca_q   <= ea;
        dbl_q   <= DOUBLE;
        poni_q  <= PONI;
        ptsel_q <= PTSEL;
        beat_q  <= 1'b0;
      end
      if ((state_q == S_XLATE) && !seg_fault)
        la_q <= poni_q ? xlat_la : flat_la;
      // Second beat re-enters XLATE so a page crossing uses the new page.
      if (xfer && dbl_q && !beat_q) begin
        lca_q  <= nlca;
        beat_q <= 1'b1;
      end
    end
  end

  assign ACK      = (state_q == S_XLATE) && !beat_q;
  assign BUSY     = (state_q != S_IDLE);
  assign LA       = la_q;
  assign LA_VALID = (state_q == S_OUT);
  assign LA_LAST  = (state_q == S_OUT) && (!dbl_q || beat_q);
  assign FAULT    = (state_q == S_FAULT);
  assign LCA      = lca_q;
  assign NLCA     = nlca;

endmodule

// File: tb/tb_cga_mac_xagen.sv
// Testbench for cga_mac_xagen: directed scenarios followed by randomized
// accesses, each beat checked against an arithmetic address model.
module tb_cga_mac_xagen;

  logic        MCLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        REQ = 1'b0, DOUBLE = 1'b0, CDS = 1'b0, PONI = 1'b0;
  logic [2:0]  SRC_SEL = '0;
  logic [15:0] PR = '0, BR = '0, XR = '0, RB = '0, CD = '0;
  logic [1:0]  PTSEL = '0, SEG_IDX = '0;
  logic        SEG_WE = 1'b0, SEG_VLD = 1'b0, LA_READY = 1'b0;
  logic [13:0] SEG_BASE = '0;
  logic        ACK, BUSY, LA_VALID, LA_LAST, FAULT;
  logic [23:0] LA;
  logic [15:0] LCA, NLCA;

  cga_mac_xagen #(.AW(16), .PAW(24), .PAGE_BITS(10), .PT_N(4)) dut (
    .MCLK(MCLK), .RESETN(RESETN), .REQ(REQ), .DOUBLE(DOUBLE),
    .SRC_SEL(SRC_SEL), .CDS(CDS), .PR(PR), .BR(BR), .XR(XR), .RB(RB),
    .CD(CD), .PONI(PONI), .PTSEL(PTSEL), .SEG_WE(SEG_WE),
    .SEG_IDX(SEG_IDX), .SEG_BASE(SEG_BASE), .SEG_VLD(SEG_VLD),
    .LA_READY(LA_READY), .ACK(ACK), .BUSY(BUSY), .LA(LA),
    .LA_VALID(LA_VALID), .LA_LAST(LA_LAST), .FAULT(FAULT),
    .LCA(LCA), .NLCA(NLCA)
  );

  always #5 MCLK = ~MCLK;

  int n_checks = 0;
  int n_errors = 0;
  string cur_name = "reset";

  // reference model state
  int unsigned m_base [4];
  bit          m_vld  [4];
  int unsigned m_lca;

  // per-access stimulus knobs
  int          t_src;
  bit          t_cds, t_dbl, t_poni, t_hold, t_kill, t_wrx;
  int          t_ptsel, t_stall;
  int unsigned t_wrx_base;
  int unsigned got_la [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur_name, tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_base[i] = 0;
      m_vld[i]  = 1'b0;
    end
    m_lca = 0;
  endtask

  function automatic int unsigned operand_of(input int sel);
    case (sel)
      0: return 32'(PR);
      1: return 32'(BR);
      2: return 32'(XR);
      3: return 32'(RB);
      4: return m_lca;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned phys_of(input int unsigned addr, input bit poni, input int pt);
    if (!poni) return addr;
    return ((m_base[pt] + addr / 1024) % 16384) * 1024 + addr % 1024;
  endfunction

  task automatic set_defaults();
    t_src = 0; t_cds = 0; t_dbl = 0; t_poni = 0; t_ptsel = 0;
    t_stall = 0; t_hold = 0; t_kill = 0; t_wrx = 0; t_wrx_base = 0;
  endtask

  task automatic seg_write(input int idx, input int unsigned base, input bit vld);
    SEG_WE = 1'b1; SEG_IDX = 2'(idx); SEG_BASE = 14'(base); SEG_VLD = vld;
    tick();
    SEG_WE = 1'b0;
    m_base[idx] = base % 16384;
    m_vld[idx]  = vld;
  endtask

  task automatic run_access(input string nm);
    int unsigned ea, addr, exp_la, cdv;
    bit flt;
    int beats;
    cur_name = nm;
    got_la[0] = 0; got_la[1] = 0;
    cdv = t_cds ? 32'(CD) : 0;
    ea = (operand_of(t_src) + cdv) % 65536;
    beats = t_dbl ? 2 : 1;
    chk("idle_busy", BUSY, 0);
    REQ = 1'b1; SRC_SEL = 3'(t_src); CDS = t_cds; DOUBLE = t_dbl;
    PONI = t_poni; PTSEL = 2'(t_ptsel);
    tick();
    if (!t_hold) REQ = 1'b0;
    chk("ack", ACK, 1);
    chk("busy", BUSY, 1);
    chk("valid_xlate", LA_VALID, 0);
    chk("lca", LCA, ea);
    m_lca = ea;
    for (int b = 0; b < beats; b++) begin
      addr = m_lca;
      flt = t_poni && !m_vld[t_ptsel];
      exp_la = phys_of(addr, t_poni, t_ptsel);
      if (b == 0 && t_wrx) begin
        SEG_WE = 1'b1; SEG_IDX = 2'(t_ptsel); SEG_BASE = 14'(t_wrx_base); SEG_VLD = 1'b1;
      end
      tick();
      if (b == 0 && t_wrx) begin
        SEG_WE = 1'b0;
        m_base[t_ptsel] = t_wrx_base % 16384;
        m_vld[t_ptsel] = 1'b1;
      end
      chk("ack_low", ACK, 0);
      if (flt) begin
        chk("fault", FAULT, 1);
        chk("fault_novalid", LA_VALID, 0);
        chk("fault_lca", LCA, addr);
        tick();
        REQ = 1'b0;
        chk("fault_end", FAULT, 0);
        chk("fault_busy", BUSY, 0);
        return;
      end
      chk("nofault", FAULT, 0);
      chk("valid", LA_VALID, 1);
      chk("la", LA, exp_la);
      chk("last", LA_LAST, (b == beats - 1) ? 1 : 0);
      chk("lca_beat", LCA, addr);
      chk("nlca", NLCA, (addr + 1) % 65536);
      got_la[b] = 32'(LA);
      for (int s = 0; s < t_stall; s++) begin
        tick();
        chk("stall_valid", LA_VALID, 1);
        chk("stall_la", LA, exp_la);
      end
      if (b == 0 && t_kill) begin
        SEG_WE = 1'b1; SEG_IDX = 2'(t_ptsel); SEG_BASE = '0; SEG_VLD = 1'b0;
        tick();
        SEG_WE = 1'b0;
        m_base[t_ptsel] = 0;
        m_vld[t_ptsel] = 1'b0;
        chk("kill_la_held", LA, exp_la);
      end
      LA_READY = 1'b1;
      tick();
      LA_READY = 1'b0;
      if (b < beats - 1) begin
        m_lca = (m_lca + 1) % 65536;
        chk("gap_valid", LA_VALID, 0);
        chk("gap_busy", BUSY, 1);
      end else begin
        REQ = 1'b0;
        chk("done_busy", BUSY, 0);
        chk("done_valid", LA_VALID, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    set_defaults();
    tick();
    tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", LA_VALID, 0);
    chk("rst_la", LA, 0);
    chk("rst_lca", LCA, 0);
    chk("rst_nlca", NLCA, 1);
    chk("rst_ack", ACK, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_last", LA_LAST, 0);
    RESETN = 1'b1;
    tick();

    // flat single beat
    set_defaults();
    PR = 16'h1234;
    run_access("flat");
    chk("flat_la_const", got_la[0], 32'h001234);

    // translated with displacement
    seg_write(2, 14'h0100, 1'b1);
    set_defaults();
    XR = 16'h0C05; CD = 16'h0001;
    t_src = 2; t_cds = 1; t_poni = 1; t_ptsel = 2;
    run_access("xlate_cd");
    chk("xlate_lca_const", LCA, 16'h0C06);
    chk("xlate_la_const", got_la[0], 32'h040C06);

    // double access crossing a page
    seg_write(0, 0, 1'b1);
    set_defaults();
    BR = 16'h03FF;
    t_src = 1; t_dbl = 1; t_poni = 1; t_ptsel = 0;
    run_access("page_cross");
    chk("pc_b1", got_la[0], 32'h0003FF);
    chk("pc_b2", got_la[1], 32'h000400);
    chk("pc_lca", LCA, 16'h0400);
    chk("pc_nlca", NLCA, 16'h0401);

    // double access wrapping the logical space
    set_defaults();
    RB = 16'hFFFF;
    t_src = 3; t_dbl = 1;
    run_access("wrap");
    chk("wrap_b1", got_la[0], 32'h00FFFF);
    chk("wrap_b2", got_la[1], 32'h000000);
    chk("wrap_lca", LCA, 0);

    // invalid entry faults even when written during XLATE
    set_defaults();
    PR = 16'h2345;
    t_poni = 1; t_ptsel = 1; t_wrx = 1; t_wrx_base = 14'h0055;
    run_access("fault_wr");
    set_defaults();
    t_poni = 1; t_ptsel = 1; t_hold = 1;
    run_access("after_wr");

    // beat-2 fault: entry invalidated while beat 1 is stalled
    set_defaults();
    PR = 16'h07FF;
    t_dbl = 1; t_poni = 1; t_ptsel = 1; t_kill = 1; t_stall = 1;
    run_access("beat2_fault");
    chk("b2f_lca", LCA, 16'h0800);

    // back-pressure then reset mid-OUT
    cur_name = "stall_reset";
    PR = 16'hABCD; SRC_SEL = 3'd0; CDS = 1'b0; DOUBLE = 1'b0; PONI = 1'b0;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
    tick();
    chk("sr_valid", LA_VALID, 1);
    chk("sr_la", LA, 24'h00ABCD);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("sr_hold_valid", LA_VALID, 1);
      chk("sr_hold_la", LA, 24'h00ABCD);
    end
    #2;
    RESETN = 1'b0;
    #1;
    chk("sr_valid0", LA_VALID, 0);
    chk("sr_busy0", BUSY, 0);
    chk("sr_la0", LA, 0);
    chk("sr_lca0", LCA, 0);
    model_reset();
    tick();
    chk("sr_nofault", FAULT, 0);
    RESETN = 1'b1;
    tick();
    set_defaults();
    PR = 16'h0042;
    t_hold = 1;
    run_access("post_reset");
    set_defaults();
    t_poni = 1; t_ptsel = 2;
    run_access("post_reset_seg");

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        seg_write(int'($urandom_range(0, 3)), $urandom_range(0, 16383), 1'($urandom_range(0, 3) != 0));
      PR = 16'($urandom); BR = 16'($urandom); XR = 16'($urandom);
      RB = 16'($urandom); CD = 16'($urandom);
      if ($urandom_range(0, 3) == 0) PR = 16'h03FF | 16'($urandom);
      set_defaults();
      t_src   = int'($urandom_range(0, 7));
      t_cds   = 1'($urandom_range(0, 1));
      t_dbl   = 1'($urandom_range(0, 1));
      t_poni  = 1'($urandom_range(0, 1));
      t_ptsel = int'($urandom_range(0, 3));
      t_stall = int'($urandom_range(0, 2));
      t_hold  = 1'($urandom_range(0, 1));
      t_kill  = t_dbl && ($urandom_range(0, 5) == 0);
      t_wrx   = ($urandom_range(0, 5) == 0);
      t_wrx_base = $urandom_range(0, 16383);
      run_access($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
